criscv_alu: RTL and testbench

Single-cycle-latency integer ALU for the criscv RV32I core. Executes the register-immediate (OP-IMM, opcode 0010011) and register-register (OP, opcode 0110011) instruction classes from decoded operand and control fields, registering the 32-bit result for write-back to the register file. Sits beside the core's execute state, which presents operands during execute and captures `rd` at the next fetch.

---
 rtl/criscv_alu.sv | 85 ++++++++
 tb/tb_criscv_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/criscv_alu.sv
// criscv RV32I integer ALU: OP and OP-IMM classes, one-cycle registered result.
// rd holds its value across non-ALU opcodes; comp flags a fresh result.
module criscv_alu (
   input  logic        mclk,
   input  logic        reset,
   input  logic [2:0]  funct3,
   input  logic        modbit,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic [31:0] rd,
   output logic        comp
);

   logic        is_alu;
   logic        is_op;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic        shift_left;
   logic        shift_fill;
   logic [31:0] rs1_rev;
   logic [31:0] shl_result;
   logic [31:0] shift_stage [0:5];
   logic [31:0] result_next;
   logic [31:0] rd_reg;
   logic        comp_reg;

   assign is_alu = ~opcode[6] & (opcode[4:0] == 5'b10011);
   assign is_op  = opcode[5];
   assign op_b   = is_op ? rs2 : imm;
   assign shamt  = op_b[4:0];

   // One right-shifting log shifter serves all three shifts; SLL runs on bit-reversed data.
   assign shift_left = (funct3 == 3'b001);
   assign shift_fill = modbit & rs1[31] & ~shift_left;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_rev
         assign rs1_rev[gi]    = rs1[31-gi];
         assign shl_result[gi] = shift_stage[5][31-gi];
      end
   endgenerate

   assign shift_stage[0] = shift_left ? rs1_rev : rs1;

   generate
      for (gi = 0; gi < 5; gi++) begin : g_shift
         assign shift_stage[gi+1] = shamt[gi]
            ? {{(1 << gi){shift_fill}}, shift_stage[gi][31:(1 << gi)]}
            : shift_stage[gi];
      end
   endgenerate

   always_comb begin
      result_next = 32'd0;
      case (funct3)
         3'b000:  result_next = (is_op & modbit) ? (rs1 - op_b) : (rs1 + op_b);
         3'b001:  result_next = shl_result;
         3'b010:  result_next = {31'd0, ($signed(rs1) < $signed(op_b))};
         3'b011:  result_next = {31'd0, (rs1 < op_b)};
         3'b100:  result_next = rs1 ^ op_b;
         3'b101:  result_next = shift_stage[5];
         3'b110:  result_next = rs1 | op_b;
         default: result_next = rs1 & op_b;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (!reset) begin
         rd_reg   <= 32'd0;
         comp_reg <= 1'b0;
      end else begin
         comp_reg <= is_alu;
         if (is_alu) begin
            rd_reg <= result_next;
         end
      end
   end

   assign rd   = rd_reg;
   assign comp = comp_reg;

endmodule

// File: tb/tb_criscv_alu.sv
// Scoreboard bench for criscv_alu: expectations queued at drive time,
// compared one cycle later against rd/comp.
module tb_criscv_alu;

   localparam logic [6:0] OPI  = 7'b0010011;
   localparam logic [6:0] OPR  = 7'b0110011;
   localparam logic [6:0] LOAD = 7'b0000011;

   logic        mclk = 1'b0;
   logic        reset;
   logic [2:0]  funct3;
   logic        modbit;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] rd;
   logic        comp;

   typedef struct {
      string       tag;
      logic [31:0] exp_rd;
      logic        exp_comp;
   } txn_t;

   txn_t        sb_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] last_rd = 32'd0;

   criscv_alu dut (
      .mclk   (mclk),
      .reset  (reset),
      .funct3 (funct3),
      .modbit (modbit),
      .imm    (imm),
      .opcode (opcode),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .comp   (comp)
   );

   always #5 mclk = ~mclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   always @(posedge mclk) begin
      #1;
      if (sb_q.size() > 0) begin
         txn_t t;
         t = sb_q.pop_front();
         $display("txn %-10s rd=%08h comp=%0b (exp rd=%08h comp=%0b)",
                  t.tag, rd, comp, t.exp_rd, t.exp_comp);
         check({t.tag, ".rd"}, rd, t.exp_rd);
         check({t.tag, ".comp"}, {31'd0, comp}, {31'd0, t.exp_comp});
      end
   end

   function automatic logic [31:0] model(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic mb, input logic [31:0] im,
                                         input logic [31:0] a, input logic [31:0] r2);
      logic [31:0] b;
      logic [31:0] res;
      b = opc[5] ? r2 : im;
      res = 32'd0;
      case (f3)
         3'd0: res = (opc[5] && mb) ? a - b : a + b;
         3'd1: res = a << b[4:0];
         3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3: res = (a < b) ? 32'd1 : 32'd0;
         3'd4: res = a ^ b;
         3'd5: begin
            if (mb) res = $signed(a) >>> b[4:0];
            else    res = a >> b[4:0];
         end
         3'd6: res = a | b;
         default: res = a & b;
      endcase
      return res;
   endfunction

   task automatic drive(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic mb, input logic [31:0] im, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_rd, input logic exp_comp);
      txn_t t;
      @(negedge mclk);
      reset  = 1'b1;
      opcode = opc;
      funct3 = f3;
      modbit = mb;
      imm    = im;
      rs1    = a;
      rs2    = b;
      t.tag = tag; t.exp_rd = exp_rd; t.exp_comp = exp_comp;
      sb_q.push_back(t);
      last_rd = exp_rd;
   endtask

   task automatic do_reset(input string tag);
      txn_t t;
      @(negedge mclk);
      reset  = 1'b0;
      opcode = OPR;
      funct3 = 3'($urandom_range(0, 7));
      modbit = 1'($urandom_range(0, 1));
      imm    = $urandom;
      rs1    = $urandom;
      rs2    = $urandom;
      t.tag = tag; t.exp_rd = 32'd0; t.exp_comp = 1'b0;
      sb_q.push_back(t);
      last_rd = 32'd0;
   endtask

   initial begin
      reset  = 1'b0;
      opcode = 7'd0;
      funct3 = 3'd0;
      modbit = 1'b0;
      imm    = 32'd0;
      rs1    = 32'd0;
      rs2    = 32'd0;

      do_reset("reset0");
      do_reset("reset1");
      drive("release", 7'd0,  3'd0, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h1, 32'h0, 1'b0);

      drive("add_wrap",  OPR, 3'd0, 1'b0, 32'h0000_0055, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000, 1'b1);
      drive("sub",       OPR, 3'd0, 1'b1, 32'h0000_0000, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b1);
      drive("addi",      OPI, 3'd0, 1'b1, 32'hFFFF_FC00, 32'h400, 32'h0001_2345, 32'h0, 1'b1);
      drive("srl",       OPR, 3'd5, 1'b0, 32'h0, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b1);
      drive("sra",       OPR, 3'd5, 1'b1, 32'h0, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b1);
      drive("slli",      OPI, 3'd1, 1'b0, 32'd31, 32'h1, 32'h0, 32'h8000_0000, 1'b1);
      drive("slt",       OPR, 3'd2, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1);
      drive("sltu",      OPR, 3'd3, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
      drive("sltiu",     OPI, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h5, 32'h0, 32'h1, 1'b1);
      drive("xor",       OPR, 3'd4, 1'b0, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b1);
      drive("or",        OPR, 3'd6, 1'b0, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b1);
      drive("and",       OPR, 3'd7, 1'b0, 32'h0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b1);
      drive("add3",      OPR, 3'd0, 1'b0, 32'h0, 32'h1, 32'h2, 32'h3, 1'b1);
      drive("load_hold", LOAD, 3'd2, 1'b0, 32'h7, 32'hAAAA_AAAA, 32'h5555_5555, 32'h3, 1'b0);
      do_reset("mid_reset");

      for (int i = 0; i < 40; i++) begin
         logic [6:0]  opc;
         logic [2:0]  f3;
         logic        mb;
         logic [11:0] i12;
         logic [31:0] im, a, b, exp;
         logic        alu;
         case ($urandom_range(0, 3))
            0: opc = OPI;
            1: opc = OPR;
            2: opc = LOAD;
            default: opc = 7'($urandom);
         endcase
         f3  = 3'($urandom_range(0, 7));
         mb  = 1'($urandom_range(0, 1));
         i12 = 12'($urandom);
         im  = {{20{i12[11]}}, i12};
         a   = $urandom;
         b   = (i % 4 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
         alu = (opc[6] == 1'b0) && (opc[4:0] == 5'b10011);
         exp = alu ? model(opc, f3, mb, im, a, b) : last_rd;
         drive($sformatf("rnd%0d", i), opc, f3, mb, im, a, b, exp, alu);
      end

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge mclk);
      @(negedge mclk);
      if (sb_q.size() != 0) check("drain", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
